// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle HI/LO multiply/divide sequencer driving a shared adder
// Define MULDIV_SIGNED_EN for signed MULT/DIV (operand pre-negate and result post-negate states).
module muldiv_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              flush,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] add_a,
  output logic [DATA_W-1:0] add_b,
  output logic              add_ci,
  input  logic [DATA_W-1:0] add_s,
  input  logic              add_co
);
`ifdef MULDIV_SIGNED_EN
  typedef enum logic [2:0] {S_IDLE, S_ITER, S_DONE, S_PRE_A, S_PRE_B, S_POST_LO, S_POST_HI} state_t;
  logic sa_q, sa_d, sb_q, sb_d, c_q, c_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_ITER, S_DONE} state_t;
  logic unused_op1;
  assign unused_op1 = op[1];
`endif

  state_t state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d, mq_q, mq_d, opnd_q, opnd_d;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
  logic              div_q, div_d, dbz_q, dbz_d;
  logic [DATA_W-1:0] div_t;
  logic              div_acc;

  // acc doubles as the partial remainder; mq holds multiplier or dividend/quotient
  assign div_t   = {acc_q[DATA_W-2:0], mq_q[DATA_W-1]};
  assign div_acc = add_co | acc_q[DATA_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef MULDIV_SIGNED_EN
      S_IDLE:    if (start) state_d = S_PRE_A;
      S_PRE_A:   state_d = S_PRE_B;
      S_PRE_B:   state_d = S_ITER;
      S_ITER:    if (cnt_q == 6'd31) state_d = S_POST_LO;
      S_POST_LO: state_d = S_POST_HI;
      S_POST_HI: state_d = S_DONE;
`else
      S_IDLE:    if (start) state_d = S_ITER;
      S_ITER:    if (cnt_q == 6'd31) state_d = S_DONE;
`endif
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (flush && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    ready  = (state_q == S_IDLE);
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    case (state_q)
      S_ITER: begin
        if (div_q) begin
          add_a  = div_t;
          add_b  = ~opnd_q;
          add_ci = 1'b1;
        end else begin
          add_a  = acc_q;
          add_b  = mq_q[0] ? opnd_q : '0;
        end
      end
`ifdef MULDIV_SIGNED_EN
      S_PRE_A: begin
        add_a  = ~(div_q ? mq_q : opnd_q);
        add_ci = 1'b1;
      end
      S_PRE_B: begin
        add_a  = ~(div_q ? opnd_q : mq_q);
        add_ci = 1'b1;
      end
      S_POST_LO: begin
        add_a  = ~mq_q;
        add_ci = 1'b1;
      end
      S_POST_HI: begin
        add_a  = ~acc_q;
        add_ci = div_q ? 1'b1 : c_q;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    mq_d   = mq_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    dbz_d  = dbz_q;
`ifdef MULDIV_SIGNED_EN
    sa_d = sa_q;
    sb_d = sb_q;
    c_d  = c_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        cnt_d  = '0;
        acc_d  = '0;
        div_d  = op[0];
        dbz_d  = 1'b0;
        mq_d   = op[0] ? src_a : src_b;
        opnd_d = op[0] ? src_b : src_a;
`ifdef MULDIV_SIGNED_EN
        sa_d = op[1] & src_a[DATA_W-1];
        sb_d = op[1] & src_b[DATA_W-1];
`endif
      end
      S_ITER: begin
        cnt_d = cnt_q + 6'd1;
        if (div_q) begin
          acc_d = div_acc ? add_s : div_t;
          mq_d  = {mq_q[DATA_W-2:0], div_acc};
        end else begin
          acc_d = {add_co, add_s[DATA_W-1:1]};
          mq_d  = {add_s[0], mq_q[DATA_W-1:1]};
        end
`ifndef MULDIV_SIGNED_EN
        if (cnt_q == 6'd31) begin
          hi_d  = acc_d;
          lo_d  = mq_d;
          dbz_d = div_q && (opnd_q == '0);
        end
`endif
      end
`ifdef MULDIV_SIGNED_EN
      S_PRE_A: if (sa_q) begin
        if (div_q) mq_d = add_s;
        else       opnd_d = add_s;
      end
      S_PRE_B: if (sb_q) begin
        if (div_q) opnd_d = add_s;
        else       mq_d = add_s;
      end
      S_POST_LO: begin
        c_d = add_co;
        if (sa_q ^ sb_q) mq_d = add_s;
      end
      S_POST_HI: begin
        if (div_q ? sa_q : (sa_q ^ sb_q)) acc_d = add_s;
        hi_d  = acc_d;
        lo_d  = mq_d;
        dbz_d = div_q && (opnd_q == '0);
      end
`endif
      default: ;
    endcase
    // an aborted operation must never reach the architectural HI/LO
    if (flush && state_q != S_IDLE) begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      dbz_d = dbz_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      mq_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dbz_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      c_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      mq_q   <= mq_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dbz_q  <= dbz_d;
`ifdef MULDIV_SIGNED_EN
      sa_q <= sa_d;
      sb_q <= sb_d;
      c_q  <= c_d;
`endif
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - scoreboard bench for muldiv_seq with a behavioural shared adder
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0, src_b = '0;
  logic        ready, busy, done, div_by_zero, add_ci, add_co;
  logic [31:0] hi, lo, add_a, add_b, add_s;

`ifdef MULDIV_SIGNED_EN
  localparam int LAT = 36;
`else
  localparam int LAT = 32;
`endif

  muldiv_seq #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .ready(ready), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero), .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co)
  );

  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_ci};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_mon;
  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    logic signed [63:0] pa, pb;
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
`ifdef MULDIV_SIGNED_EN
    sgn = o[1];
`else
    sgn = 1'b0;
`endif
    sa = a;
    sb = b;
    if (!o[0]) begin
      pa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      pb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      return pa * pb;
    end
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input string tag, output int acc);
    logic [63:0] r;
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    if (push) begin
      r = model(o, a, b);
      sb_q.push_back('{tag, r[63:32], r[31:0], (o[0] && b == 0), acc});
      last_hi = r[63:32];
      last_lo = r[31:0];
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check({tag, "_idle_add"}, add_a | add_b | {31'd0, add_ci}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
      else begin
        e_mon = sb_q.pop_front();
        check({e_mon.tag, "_hi"}, hi, e_mon.hi);
        check({e_mon.tag, "_lo"}, lo, e_mon.lo);
        check({e_mon.tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e_mon.dbz});
        check({e_mon.tag, "_lat"}, cyc - e_mon.acc, LAT);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_hi"}, hi, 32'd0);
    check({tag, "_lo"}, lo, 32'd0);
    check({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
    check({tag, "_add"}, add_a | add_b | {31'd0, add_ci}, 32'd0);
  endtask

  initial begin
    int acc;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu_max", acc);
    wait_done("multu_max");

    launch(2'b00, 32'd3, 32'd4, 1'b1, "multu_trace", acc);
    check("trace0_add_b", add_b, 32'd0);
    check("trace0_add_ci", {31'd0, add_ci}, 32'd0);
    @(negedge clk);
    check("trace1_add_b", add_b, 32'd0);
    @(negedge clk);
    check("trace2_add_b", add_b, 32'd3);
    wait_done("multu_trace");

    launch(2'b01, 32'd100, 32'd7, 1'b1, "divu_100_7", acc);
    wait_done("divu_100_7");
    launch(2'b01, 32'h1234_5678, 32'd0, 1'b1, "divu_by0", acc);
    wait_done("divu_by0");

    flush = 1'b1;
    launch(2'b00, 32'd2, 32'd3, 1'b1, "flush_start", acc);
    flush = 1'b0;
    wait_done("flush_start");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i == 2) ? 32'd1 : $urandom >> (i * 5);
      launch({1'b0, i[0]}, ra, rb, 1'b1, $sformatf("rand%0d", i), acc);
      wait_done($sformatf("rand%0d", i));
    end

    launch(2'b00, 32'd3, 32'd5, 1'b0, "flush_op", acc);
    while (cyc < acc + 4) @(negedge clk);
    op = 2'b00; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + 9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", {31'd0, ready}, 32'd1);
    check("flush_hi", hi, last_hi);
    check("flush_lo", lo, last_lo);
    repeat (40) @(negedge clk);
    check("flush_no_restart", {31'd0, ready}, 32'd1);

    launch(2'b01, 32'd1000, 32'd3, 1'b0, "rst_op", acc);
    while (cyc < acc + 20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    last_hi = '0;
    last_lo = '0;
    launch(2'b00, 32'd6, 32'd7, 1'b1, "multu_6_7", acc);
    wait_done("multu_6_7");

`ifdef MULDIV_SIGNED_EN
    launch(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b1, "mult_m3_5", acc);
    wait_done("mult_m3_5");
    launch(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2", acc);
    wait_done("div_m7_2");
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
